// File: rtl/memory_stage_if.sv
// AXI4-Lite-style SoC master bus used by the memory stage: AR/R/AW/W/B channels, 32-bit data/address.
interface memory_stage_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/memory_stage.sv
// Memory stage: one bus transaction per load/store, aligned/extended load data on memory_o_valM.
// Latency: 3 cycles minimum to done, +1 per slave wait cycle; stalls upstream until done.
// Backpressure: channel outputs held while valid && !ready; MEM_MISALIGN_TRAP_EN traps misaligned accesses.
module memory_stage (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           regM_i_valE,
  input  logic [31:0]           regM_i_valB,
  input  logic [3:0]            regM_i_mem_rw,
  output logic [31:0]           memory_o_valM,
  output logic                  memory_o_stall,
  output logic                  memory_o_done,
  output logic                  memory_o_bus_err,
  output logic                  memory_o_misalign,
  memory_stage_if.master        io_master
);

  localparam logic [3:0] OP_LB  = 4'b0001;
  localparam logic [3:0] OP_LH  = 4'b0010;
  localparam logic [3:0] OP_LW  = 4'b0011;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_LHU = 4'b0101;
  localparam logic [3:0] OP_SB  = 4'b1001;
  localparam logic [3:0] OP_SH  = 4'b1010;
  localparam logic [3:0] OP_SW  = 4'b1011;

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_t;

  state_t     state;
  logic       aw_done;
  logic       w_done;
  logic [3:0] op_q;
  logic [1:0] off_q;

  logic       is_load;
  logic       is_store;
  logic       mis;
  logic       aw_fire;
  logic       w_fire;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;

  assign is_load  = (regM_i_mem_rw >= OP_LB) && (regM_i_mem_rw <= OP_LHU);
  assign is_store = (regM_i_mem_rw >= OP_SB) && (regM_i_mem_rw <= OP_SW);

`ifdef MEM_MISALIGN_TRAP_EN
  assign mis = (((regM_i_mem_rw == OP_LH) || (regM_i_mem_rw == OP_LHU) || (regM_i_mem_rw == OP_SH))
                && regM_i_valE[0])
            || (((regM_i_mem_rw == OP_LW) || (regM_i_mem_rw == OP_SW))
                && (regM_i_valE[1:0] != 2'b00));
`else
  assign mis = 1'b0;
`endif

  // Store data is replicated so the strobe alone selects the target lanes.
  always_comb begin
    st_wdata = regM_i_valB;
    st_wstrb = 4'b1111;
    case (regM_i_mem_rw)
      OP_SB: begin
        st_wdata = {4{regM_i_valB[7:0]}};
        st_wstrb = 4'b0001 << regM_i_valE[1:0];
      end
      OP_SH: begin
        st_wdata = {2{regM_i_valB[15:0]}};
        st_wstrb = 4'b0011 << regM_i_valE[1:0];
      end
      default: begin
        st_wdata = regM_i_valB;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  function automatic logic [31:0] load_extract(input logic [3:0] op, input logic [1:0] off,
                                               input logic [31:0] rdata);
    logic [31:0] s;
    s = rdata >> {off, 3'b000};
    case (op)
      OP_LB:   load_extract = {{24{s[7]}}, s[7:0]};
      OP_LBU:  load_extract = {24'd0, s[7:0]};
      OP_LH:   load_extract = {{16{s[15]}}, s[15:0]};
      OP_LHU:  load_extract = {16'd0, s[15:0]};
      default: load_extract = rdata;
    endcase
  endfunction

  assign aw_fire = io_master.awvalid && io_master.awready;
  assign w_fire  = io_master.wvalid && io_master.wready;

  assign memory_o_stall = ((state == IDLE) && (is_load || is_store))
                       || ((state != IDLE) && (state != DONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      aw_done            <= 1'b0;
      w_done             <= 1'b0;
      op_q               <= 4'd0;
      off_q              <= 2'd0;
      memory_o_valM      <= 32'd0;
      memory_o_done      <= 1'b0;
      memory_o_bus_err   <= 1'b0;
      memory_o_misalign  <= 1'b0;
      io_master.araddr   <= 32'd0;
      io_master.arvalid  <= 1'b0;
      io_master.rready   <= 1'b0;
      io_master.awaddr   <= 32'd0;
      io_master.awvalid  <= 1'b0;
      io_master.wdata    <= 32'd0;
      io_master.wstrb    <= 4'd0;
      io_master.wvalid   <= 1'b0;
      io_master.bready   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          op_q  <= regM_i_mem_rw;
          off_q <= regM_i_valE[1:0];
          if (mis) begin
            state             <= DONE;
            memory_o_done     <= 1'b1;
            memory_o_misalign <= 1'b1;
            memory_o_bus_err  <= 1'b0;
          end else if (is_load) begin
            state             <= RD_ADDR;
            io_master.arvalid <= 1'b1;
            io_master.araddr  <= regM_i_valE;
          end else if (is_store) begin
            state             <= WR_REQ;
            aw_done           <= 1'b0;
            w_done            <= 1'b0;
            io_master.awvalid <= 1'b1;
            io_master.awaddr  <= regM_i_valE;
            io_master.wvalid  <= 1'b1;
            io_master.wdata   <= st_wdata;
            io_master.wstrb   <= st_wstrb;
          end
        end
        RD_ADDR: begin
          if (io_master.arready) begin
            io_master.arvalid <= 1'b0;
            io_master.rready  <= 1'b1;
            state             <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (io_master.rvalid) begin
            io_master.rready <= 1'b0;
            memory_o_valM    <= load_extract(op_q, off_q, io_master.rdata);
            memory_o_bus_err <= (io_master.rresp != 2'b00);
            memory_o_done    <= 1'b1;
            state            <= DONE;
          end
        end
        WR_REQ: begin
          if (aw_fire) begin
            io_master.awvalid <= 1'b0;
            aw_done           <= 1'b1;
          end
          if (w_fire) begin
            io_master.wvalid <= 1'b0;
            w_done           <= 1'b1;
          end
          // Either channel may finish first; leave once both have.
          if ((aw_done || aw_fire) && (w_done || w_fire)) begin
            io_master.bready <= 1'b1;
            state            <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (io_master.bvalid) begin
            io_master.bready <= 1'b0;
            memory_o_bus_err <= (io_master.bresp != 2'b00);
            memory_o_done    <= 1'b1;
            state            <= DONE;
          end
        end
        DONE: begin
          memory_o_done     <= 1'b0;
          memory_o_bus_err  <= 1'b0;
          memory_o_misalign <= 1'b0;
          state             <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Randomized bench for memory_stage: a delayed-ready slave plus an arithmetic reference of each access.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] valE;
  logic [31:0] valB;
  logic [3:0]  mem_rw;
  logic [31:0] valM;
  logic        stall;
  logic        done;
  logic        bus_err;
  logic        misalign;

  memory_stage_if io_master();

  memory_stage dut (
    .clk               (clk),
    .rst               (rst),
    .regM_i_valE       (valE),
    .regM_i_valB       (valB),
    .regM_i_mem_rw     (mem_rw),
    .memory_o_valM     (valM),
    .memory_o_stall    (stall),
    .memory_o_done     (done),
    .memory_o_bus_err  (bus_err),
    .memory_o_misalign (misalign),
    .io_master         (io_master)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_valm = 32'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int acc_size(input int code);
    case (code)
      1, 4, 9:  return 1;
      2, 5, 10: return 2;
      default:  return 4;
    endcase
  endfunction

  function automatic bit ref_trap(input int code, input logic [31:0] addr);
`ifdef MEM_MISALIGN_TRAP_EN
    return (acc_size(code) > 1) && ((addr % acc_size(code)) != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] ref_load(input int code, input logic [31:0] addr,
                                           input logic [31:0] rd);
    logic [31:0] s;
    logic [31:0] b;
    s = rd >> (8 * (addr % 4));
    case (code)
      1: begin b = s & 32'hFF;   return (b >= 128)   ? b - 32'd256     : b; end
      4: return s & 32'hFF;
      2: begin b = s & 32'hFFFF; return (b >= 32768) ? b - 32'h1_0000  : b; end
      5: return s & 32'hFFFF;
      default: return rd;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input int code, input logic [31:0] d);
    case (code)
      9:       return (d & 32'hFF) * 32'h0101_0101;
      10:      return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] ref_wstrb(input int code, input logic [31:0] addr);
    logic [3:0] m;
    int off;
    m   = 4'd0;
    off = (code == 11) ? 0 : int'(addr % 4);
    for (int i = 0; i < 4; i++)
      if (i >= off && i < off + acc_size(code)) m[i] = 1'b1;
    return m;
  endfunction

  task automatic bus_idle();
    io_master.arready = 1'b0;
    io_master.rvalid  = 1'b0;
    io_master.rdata   = 32'd0;
    io_master.rresp   = 2'd0;
    io_master.awready = 1'b0;
    io_master.wready  = 1'b0;
    io_master.bvalid  = 1'b0;
    io_master.bresp   = 2'd0;
  endtask

  // Starts at a negedge with the stage idle; returns one cycle after done.
  task automatic access(input int code, input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] rd, input logic [1:0] resp,
                        input int ar_w, input int r_w, input int aw_w, input int w_w, input int b_w);
    bit is_ld, trap, got_done, stall_bad, unstable;
    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt, lat, exp_lat, mx;
    logic [31:0] cap_araddr, cap_awaddr, cap_wdata, d_valm;
    logic [3:0]  cap_wstrb;
    logic        d_err, d_mis, d_stall;
    logic [31:0] p_araddr, p_awaddr, p_wdata;
    logic [3:0]  p_wstrb;
    bit p_ar_hold, p_aw_hold, p_w_hold;
    is_ld = (code <= 5);
    trap  = ref_trap(code, addr);
    {got_done, stall_bad, unstable, p_ar_hold, p_aw_hold, p_w_hold} = '0;
    {ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt, lat} = '0;
    {cap_araddr, cap_awaddr, cap_wdata, cap_wstrb, d_valm} = '0;
    {p_araddr, p_awaddr, p_wdata, p_wstrb, d_err, d_mis, d_stall} = '0;
    valE   = addr;
    valB   = data;
    mem_rw = 4'(code);
    #1 check("stall_c0", stall, 1'b1);
    for (int c = 1; c <= 60 && !got_done; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        got_done = 1; lat = c; d_valm = valM; d_err = bus_err; d_mis = misalign; d_stall = stall;
      end else if (stall !== 1'b1) stall_bad = 1;
      if (p_ar_hold && (!io_master.arvalid || io_master.araddr !== p_araddr)) unstable = 1;
      if (p_aw_hold && (!io_master.awvalid || io_master.awaddr !== p_awaddr)) unstable = 1;
      if (p_w_hold && (!io_master.wvalid || io_master.wdata !== p_wdata ||
                       io_master.wstrb !== p_wstrb)) unstable = 1;
      io_master.arready = io_master.arvalid && (ar_cnt >= ar_w);
      if (io_master.arvalid) begin
        if (io_master.arready) cap_araddr = io_master.araddr;
        ar_cnt++;
      end
      io_master.rvalid = io_master.rready && (r_cnt >= r_w);
      io_master.rdata  = io_master.rvalid ? rd : $urandom;
      io_master.rresp  = resp;
      if (io_master.rready) r_cnt++;
      io_master.awready = io_master.awvalid && (aw_cnt >= aw_w);
      if (io_master.awvalid) begin
        if (io_master.awready) cap_awaddr = io_master.awaddr;
        aw_cnt++;
      end
      io_master.wready = io_master.wvalid && (w_cnt >= w_w);
      if (io_master.wvalid) begin
        if (io_master.wready) begin cap_wdata = io_master.wdata; cap_wstrb = io_master.wstrb; end
        w_cnt++;
      end
      io_master.bvalid = io_master.bready && (b_cnt >= b_w);
      io_master.bresp  = resp;
      if (io_master.bready) b_cnt++;
      p_ar_hold = io_master.arvalid && !io_master.arready; p_araddr = io_master.araddr;
      p_aw_hold = io_master.awvalid && !io_master.awready; p_awaddr = io_master.awaddr;
      p_w_hold  = io_master.wvalid && !io_master.wready;
      p_wdata   = io_master.wdata; p_wstrb = io_master.wstrb;
    end
    bus_idle();
    mem_rw = 4'd0;
    if (!got_done) begin
      check("timeout", 32'd0, 32'd1);
      return;
    end
    mx = (aw_w > w_w) ? aw_w : w_w;
    if (trap)       exp_lat = 1;
    else if (is_ld) exp_lat = 3 + ar_w + r_w;
    else            exp_lat = 3 + mx + b_w;
    if (is_ld && !trap) exp_valm = ref_load(code, addr, rd);
    check("latency", lat, exp_lat);
    check("valM", d_valm, exp_valm);
    check("bus_err", d_err, trap ? 1'b0 : (resp != 0));
    check("misalign", d_mis, trap);
    check("stall_done", d_stall, 1'b0);
    check("stall_busy", stall_bad, 1'b0);
    check("chan_stable", unstable, 1'b0);
    if (trap) check("no_bus", ar_cnt + aw_cnt + w_cnt, 0);
    else if (is_ld) begin
      check("araddr", cap_araddr, addr);
      check("arvalid_cyc", ar_cnt, ar_w + 1);
    end else begin
      check("awaddr", cap_awaddr, addr);
      check("wdata", cap_wdata, ref_wdata(code, data));
      check("wstrb", cap_wstrb, ref_wstrb(code, addr));
      check("awvalid_cyc", aw_cnt, aw_w + 1);
      check("wvalid_cyc", w_cnt, w_w + 1);
    end
    @(posedge clk);
    @(negedge clk);
    check("done_pulse", {done, bus_err, misalign, stall}, 4'd0);
  endtask

  initial begin
    int codes[8] = '{1, 2, 3, 4, 5, 9, 10, 11};
    bit saw_done;
    bit rr;
    rst = 1'b0; valE = 32'd0; valB = 32'd0; mem_rw = 4'd0;
    bus_idle();
    #2 rst = 1'b1;
    #1;
    check("rst_regs", {io_master.arvalid, io_master.rready, io_master.awvalid, io_master.wvalid,
                       io_master.bready, done, bus_err, misalign, stall}, 9'd0);
    check("rst_valm", valM, 32'd0);
    check("rst_addr", io_master.araddr | io_master.awaddr | {28'd0, io_master.wstrb}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    access(3,  32'h8000_0004, 32'd0, 32'hDEAD_BEEF, 2'd0, 0, 0, 0, 0, 0);
    access(1,  32'h8000_0003, 32'd0, 32'h80FF_0000, 2'd0, 0, 0, 0, 0, 0);
    access(4,  32'h8000_0003, 32'd0, 32'h80FF_0000, 2'd0, 0, 0, 0, 0, 0);
    access(10, 32'h8000_0002, 32'h1234_ABCD, 32'd0, 2'd0, 0, 0, 3, 0, 0);
    access(11, 32'h8000_0008, 32'h5555_AAAA, 32'd0, 2'd2, 0, 0, 0, 0, 0);
    access(3,  32'h8000_0001, 32'd0, 32'h0BAD_F00D, 2'd0, 0, 0, 0, 0, 0);

    // Reset while RD_DATA waits on rvalid.
    valE = 32'h8000_0010; mem_rw = 4'd3;
    rr = 0;
    for (int i = 0; i < 10 && !rr; i++) begin
      @(negedge clk);
      io_master.arready = io_master.arvalid;
      rr = io_master.rready;
    end
    check("reach_rd_data", rr, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_mid_regs", {io_master.arvalid, io_master.rready, done, bus_err, misalign}, 5'd0);
    check("rst_mid_valm", valM, 32'd0);
    exp_valm = 32'd0;
    mem_rw = 4'd0;
    bus_idle();
    @(negedge clk);
    rst = 1'b0;
    saw_done = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done || stall || io_master.arvalid || io_master.rready) saw_done = 1;
    end
    check("rst_mid_idle", saw_done, 1'b0);

    for (int n = 0; n < 150; n++) begin
      int code;
      code = codes[$urandom_range(0, 7)];
      access(code, 32'h8000_0000 | ($urandom & 32'h0000_FFFF), $urandom, $urandom,
             ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
# memory_stage

Memory-access stage of the pipelined CPU, downstream of the EX/MEM register. It decodes the registered access request (`mem_rw`, address `valE`, store data `valB`), runs one AXI4-Lite-style transaction on the SoC master port, and returns aligned, extended load data as `valM`. While a transaction is in flight it stalls the pipeline, so the EX/MEM register holds its outputs stable until completion.

## Interface
- No parameters; data and address are fixed at 32 bits.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `regM_i_valE` in 32: byte address of the access.
- `regM_i_valB` in 32: store data, right-aligned.
- `regM_i_mem_rw` in 4: access code.
  - 0000: none.
  - 0001 LB, 0010 LH, 0011 LW, 0100 LBU, 0101 LHU.
  - 1001 SB, 1010 SH, 1011 SW.
  - All other codes are treated as none.
- `memory_o_valM` out 32: load result, held until the next load completes.
- `memory_o_stall` out 1: freeze the upstream pipeline.
- `memory_o_done` out 1: one-cycle pulse when an access completes.
- `memory_o_bus_err` out 1: pulse with `done` if the response code is non-zero.
- `memory_o_misalign` out 1: pulse with `done` on a trapped misaligned access.
- `io_master_araddr` out 32, `io_master_arvalid` out 1, `io_master_arready` in 1: read address channel.
- `io_master_rdata` in 32, `io_master_rresp` in 2, `io_master_rvalid` in 1, `io_master_rready` out 1: read data channel.
- `io_master_awaddr` out 32, `io_master_awvalid` out 1, `io_master_awready` in 1: write address channel.
- `io_master_wdata` out 32, `io_master_wstrb` out 4, `io_master_wvalid` out 1, `io_master_wready` in 1: write data channel.
- `io_master_bresp` in 2, `io_master_bvalid` in 1, `io_master_bready` out 1: write response channel.

## Operation
- The FSM has six states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE:
  - A load code moves to RD_ADDR.
  - A store code moves to WR_REQ and clears the `aw_done` and `w_done` flags.
  - No access stays in IDLE.
- RD_ADDR: `arvalid`=1 and `araddr`=`valE`. On `arready`, move to RD_DATA.
- RD_DATA: `rready`=1. On `rvalid`, register the extracted data into `valM`, latch the error flag (`rresp`!=0), and move to DONE.
- WR_REQ:
  - `awvalid` stays high until AW completes, then `aw_done` is set.
  - `wvalid` stays high until W completes, then `w_done` is set.
  - The two channels are independent; either may complete first or both may complete in the same cycle.
  - Move to WR_RESP in the cycle in which both are complete.
- WR_RESP: `bready`=1. On `bvalid`, latch the error flag (`bresp`!=0) and move to DONE.
- DONE: `done`=1, `bus_err` shows the latched error flag, `stall`=0, then return to IDLE.
- Stall is combinational: `stall` = (IDLE and access code valid) or (state is not IDLE and not DONE).
- Load extraction:
  - Shift: `s` = `rdata` >> (8·`valE[1:0]`).
  - LB and LBU take `s[7:0]`; LH and LHU take `s[15:0]`.
  - LB and LH sign-extend; LBU and LHU zero-extend; LW takes `rdata` whole.
- Store data is replicated across byte lanes:
  - SB: `wdata` = {4{`valB[7:0]`}}, `wstrb` = 0001<<`valE[1:0]`.
  - SH: `wdata` = {2{`valB[15:0]`}}, `wstrb` = 0011<<`valE[1:0]`, truncated to 4 bits.
  - SW: `wdata` = `valB`, `wstrb` = 1111.
- `awaddr` = `valE`, unmodified.

## Timing
- Reset values:
  - State is IDLE.
  - All valid/ready outputs, `valM`, `done`, `bus_err`, `misalign`, `wstrb`, and the addresses are 0.
- Reset mid-transaction aborts immediately to IDLE; no completion pulse is produced.
- Minimum load, with ready/valid already high: IDLE (cycle 0) → RD_ADDR (1) → RD_DATA (2) → DONE (3). `stall` is high in cycles 0–2, `valM` is valid from cycle 3.
- Minimum store: IDLE → WR_REQ → WR_RESP → DONE, so `done` arrives in cycle 3.
- Every wait cycle on the slave side adds exactly one cycle to the access.
- Outputs in each channel hold stable while valid is high and ready is low.
- After DONE the stage always spends one cycle in IDLE before it can accept a new request. A back-to-back access therefore starts in the cycle after DONE.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - These accesses are misaligned: LH, LHU or SH with `valE[0]`=1, and LW or SW with `valE[1:0]`!=0.
  - A misaligned access goes IDLE → DONE with `misalign`=1.
  - No bus activity occurs and `valM` is unchanged.
- `MEM_MISALIGN_TRAP_EN` undefined:
  - No check is made; `misalign` is tied to 0.
  - The access is issued as-is, with strobe truncation and the shift rules above.

## Test plan
- LW at 0x8000_0004 with an immediate slave returning 0xDEAD_BEEF → `araddr` 0x8000_0004; `valM`=0xDEADBEEF in cycle 3; `stall` high for cycles 0–2.
- LB at 0x8000_0003 with `rdata`=0x80FF_0000 → `valM`=0xFFFF_FF80. Repeated as LBU → 0x0000_0080.
- SH at 0x8000_0002 with `valB`=0x1234_ABCD → `wdata`=0xABCD_ABCD, `wstrb`=1100. With `awready` delayed 3 cycles and `wready` immediate, `wvalid` drops after one cycle and `awvalid` holds for 4 cycles.
- SW with `bresp`=2 → `done` and `bus_err` both pulse for 1 cycle; `valM` is unchanged.
- `rst` asserted during RD_DATA with `rvalid` low → all outputs are 0 asynchronously; after release the FSM is in IDLE and no `done` pulse occurs.
- With `MEM_MISALIGN_TRAP_EN`, LW at 0x8000_0001 → `done` and `misalign` pulse in cycle 1 and `arvalid` never rises. Without the macro, the same load issues a read and returns `rdata`.
